main_control_fsm: RTL and testbench
===================================

// Module: main_control_fsm
// PURPOSE
//  Multi-cycle main control unit for the 16-bit RISC datapath. Sequences each instruction through
//  fetch/decode/execute/memory/writeback and drives all datapath enables and muxes.
//  Sits directly upstream of ALU_Control: supplies alu_op, which ALU_Control combines with Function.
//  Stalls on a single-ready memory handshake.
// PARAMETERS
//  OPCODE_W  4  opcode width, instr[15:12]
//  STATE_W   4  state register width
//  ALUOP_W   2  width of alu_op to ALU_Control
// PORTS
//  clk            in   1         single clock, all state updates on posedge
//  reset          in   1         synchronous, active-high
//  opcode         in   OPCODE_W  IR[15:12]; held stable by IR from DECODE until next FETCH
//  mem_ready      in   1         memory completes current read/write this cycle
//  pc_write       out  1         unconditional PC load
//  pc_write_cond  out  1         PC load if ALU zero (BEQ)
//  ir_write       out  1         IR load
//  iord           out  1         0=PC addresses memory, 1=ALUOut
//  mem_read       out  1         memory read request
//  mem_write      out  1         memory write request
//  reg_write      out  1         register file write
//  reg_dst        out  1         0=rt, 1=rd
//  mem_to_reg     out  1         0=ALUOut, 1=MDR
//  alu_src_a      out  1         0=PC, 1=regA
//  alu_src_b      out  2         00=regB, 01=const 1, 10=sext imm, 11=sext offset
//  pc_src         out  2         00=ALU, 01=ALUOut, 10=jump target
//  alu_op         out  ALUOP_W   00=R-type (use Function), 01=sub, 10=add, 11=slt
//  illegal_op     out  1         1-cycle pulse: undefined opcode decoded
//  state          out  STATE_W   current state, debug
// BEHAVIOUR
//  - Reset: state<=FETCH next edge; all outputs forced 0 while reset high (overrides state decode).
//    Reset asserted in any state, including mid-memory-wait, aborts the instruction.
//  - Moore outputs decoded from state; unlisted outputs 0. Only exception: FETCH gates ir_write/pc_write with mem_ready.
//  - Opcodes: 0000 R, 0001 LW, 0010 SW, 0011 BEQ, 0100 ADDI, 0101 SLTI, 0110 J; 0111-1111 illegal.
//  - States (encoding 0..11):
//    FETCH: mem_read=1, iord=0, src_a=0, src_b=01, alu_op=10, pc_src=00
//      - ir_write=pc_write=mem_ready; stay while !mem_ready, else DECODE
//    DECODE: src_a=0, src_b=11, alu_op=10 (branch target precompute)
//      - LW/SW->MEM_ADDR; R->R_EXEC; BEQ->BRANCH; J->JUMP; ADDI/SLTI->I_EXEC
//      - illegal->FETCH with illegal_op=1
//    MEM_ADDR: src_a=1, src_b=10, alu_op=10 -> LW:MEM_READ, SW:MEM_WRITE
//    MEM_READ: mem_read=1, iord=1; stay while !mem_ready, else MEM_WB
//    MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH
//    MEM_WRITE: mem_write=1, iord=1; stay while !mem_ready, else FETCH
//    R_EXEC: src_a=1, src_b=00, alu_op=00 -> R_WB
//    R_WB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH
//    BRANCH: src_a=1, src_b=00, alu_op=01, pc_write_cond=1, pc_src=01 -> FETCH
//    JUMP: pc_write=1, pc_src=10 -> FETCH
//    I_EXEC: src_a=1, src_b=10; alu_op=10 (ADDI) or 11 (SLTI) from held opcode -> I_WB
//    I_WB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH
//  - Unused encodings 12-15 -> FETCH next cycle, all outputs 0.
//  - Zero-wait latency (cycles incl. FETCH): LW 5, SW 4, R 4, ADDI/SLTI 4, BEQ 3, J 3, illegal 2.
//  - Each extra cycle mem_ready=0 in FETCH/MEM_READ/MEM_WRITE adds one cycle; request outputs held stable while waiting.
//  - mem_ready ignored in all other states.
// STRUCTURE
//  - Shared package ctrl_pkg: opcode constants, state encodings, ALUOp encodings, alu_src_b/pc_src codes.
//  - ALU_Control consumes the same ALUOp constants from ctrl_pkg.
//  - Single module: state register plus next-state block plus output decode block. No sub-module.
// TESTING
//  - Reset: hold reset 3 cycles in MEM_READ wait -> all outputs 0 during reset; state=FETCH after release.
//  - LW, mem_ready=1 always -> states 0,1,2,3,4,0.
//    - alu_op=10 in FETCH/DECODE/MEM_ADDR; reg_write=1 and mem_to_reg=1 only in MEM_WB.
//  - SW, mem_ready low 2 cycles in MEM_WRITE -> mem_write=1, iord=1 held 3 cycles; then FETCH; total 6 cycles.
//  - R-type (0000) -> alu_op=00 in R_EXEC; R_WB has reg_write=1, reg_dst=1; back to FETCH after 4 cycles.
//  - BEQ -> BRANCH: alu_op=01, pc_write_cond=1, pc_src=01. SLTI -> I_EXEC: alu_op=11.
//  - Opcode 1010 -> illegal_op=1 for exactly one cycle in DECODE; next state FETCH; no write enables asserted.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared control constants for the multi-cycle RISC datapath.
// The main control FSM and ALU_Control both import this package, so the
// ALUOp codes below are the single agreed contract between the two blocks.
package ctrl_pkg;

   localparam int OPCODE_W = 4;
   localparam int STATE_W  = 4;
   localparam int ALUOP_W  = 2;

   // Opcodes taken from instr[15:12]
   localparam logic [3:0] OP_R    = 4'b0000;
   localparam logic [3:0] OP_LW   = 4'b0001;
   localparam logic [3:0] OP_SW   = 4'b0010;
   localparam logic [3:0] OP_BEQ  = 4'b0011;
   localparam logic [3:0] OP_ADDI = 4'b0100;
   localparam logic [3:0] OP_SLTI = 4'b0101;
   localparam logic [3:0] OP_J    = 4'b0110;

   // ALUOp codes handed to ALU_Control
   localparam logic [1:0] ALUOP_RTYPE = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_ADD   = 2'b10;
   localparam logic [1:0] ALUOP_SLT   = 2'b11;

   // Second ALU operand select
   localparam logic [1:0] SRCB_REGB   = 2'b00;
   localparam logic [1:0] SRCB_ONE    = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_OFFSET = 2'b11;

   // PC source select
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Control states; the numeric encoding is visible on the debug port
   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_R_EXEC    = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_I_EXEC    = 4'd10,
      S_I_WB      = 4'd11
   } ctrlState_e;

   // Everything from 0111 upward is undefined
   function automatic logic isLegalOpcode(input logic [3:0] op);
      return (op <= OP_J);
   endfunction

endpackage

// File: rtl/main_control_fsm.sv
// Multi-cycle main control unit: steps each instruction through
// fetch/decode/execute/memory/writeback and drives the datapath controls.
// Outputs are decoded from the current state only, except that the fetch
// cycle commits IR and PC only once memory reports ready.
module main_control_fsm
   import ctrl_pkg::*;
#(
   parameter int OPCODE_W = ctrl_pkg::OPCODE_W,
   parameter int STATE_W  = ctrl_pkg::STATE_W,
   parameter int ALUOP_W  = ctrl_pkg::ALUOP_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   output logic                pc_write,
   output logic                pc_write_cond,
   output logic                ir_write,
   output logic                iord,
   output logic                mem_read,
   output logic                mem_write,
   output logic                reg_write,
   output logic                reg_dst,
   output logic                mem_to_reg,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [1:0]          pc_src,
   output logic [ALUOP_W-1:0]  alu_op,
   output logic                illegal_op,
   output logic [STATE_W-1:0]  state
);

   ctrlState_e r_state;
   ctrlState_e w_nextState;
   logic [3:0] w_op;
   logic [1:0] w_aluOp;

   assign w_op = 4'(opcode);

   // State register; reset aborts whatever instruction is in flight
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_nextState;
   end

   // Next-state selection, memory states wait on mem_ready
   always_comb begin
      w_nextState = S_FETCH;
      case (r_state)
         S_FETCH:     w_nextState = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (w_op)
               OP_LW, OP_SW:     w_nextState = S_MEM_ADDR;
               OP_R:             w_nextState = S_R_EXEC;
               OP_BEQ:           w_nextState = S_BRANCH;
               OP_J:             w_nextState = S_JUMP;
               OP_ADDI, OP_SLTI: w_nextState = S_I_EXEC;
               default:          w_nextState = S_FETCH;
            endcase
         end
         S_MEM_ADDR:  w_nextState = (w_op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ:  w_nextState = mem_ready ? S_MEM_WB : S_MEM_READ;
         S_MEM_WRITE: w_nextState = mem_ready ? S_FETCH : S_MEM_WRITE;
         S_R_EXEC:    w_nextState = S_R_WB;
         S_I_EXEC:    w_nextState = S_I_WB;
         default:     w_nextState = S_FETCH;
      endcase
   end

   // Datapath control decode; reset forces every output low
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_REGB;
      pc_src        = PCSRC_ALU;
      w_aluOp       = ALUOP_RTYPE;
      illegal_op    = 1'b0;
      state         = '0;
      if (!reset) begin
         state = STATE_W'(r_state);
         case (r_state)
            S_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = SRCB_ONE;
               w_aluOp   = ALUOP_ADD;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            S_DECODE: begin
               alu_src_b  = SRCB_OFFSET;
               w_aluOp    = ALUOP_ADD;
               illegal_op = !isLegalOpcode(w_op);
            end
            S_MEM_ADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = SRCB_IMM;
               w_aluOp   = ALUOP_ADD;
            end
            S_MEM_READ: begin
               mem_read = 1'b1;
               iord     = 1'b1;
            end
            S_MEM_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
               mem_write = 1'b1;
               iord      = 1'b1;
            end
            S_R_EXEC: begin
               alu_src_a = 1'b1;
               alu_src_b = SRCB_REGB;
               w_aluOp   = ALUOP_RTYPE;
            end
            S_R_WB: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
            end
            S_BRANCH: begin
               alu_src_a     = 1'b1;
               alu_src_b     = SRCB_REGB;
               w_aluOp       = ALUOP_SUB;
               pc_write_cond = 1'b1;
               pc_src        = PCSRC_ALUOUT;
            end
            S_JUMP: begin
               pc_write = 1'b1;
               pc_src   = PCSRC_JUMP;
            end
            S_I_EXEC: begin
               alu_src_a = 1'b1;
               alu_src_b = SRCB_IMM;
               w_aluOp   = (w_op == OP_SLTI) ? ALUOP_SLT : ALUOP_ADD;
            end
            S_I_WB: begin
               reg_write = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign alu_op = ALUOP_W'(w_aluOp);

endmodule

// File: tb/tb_main_control_fsm.sv
// Testbench for main_control_fsm. Each instruction is expanded into the
// list of cycles it should take (from the opcode, the fetch wait count and
// the memory wait count) and every cycle's controls are compared.
module tb_main_control_fsm;

   typedef struct packed {
      logic       pcWrite;
      logic       pcWriteCond;
      logic       irWrite;
      logic       iord;
      logic       memRead;
      logic       memWrite;
      logic       regWrite;
      logic       regDst;
      logic       memToReg;
      logic       srcA;
      logic [1:0] srcB;
      logic [1:0] pcSrc;
      logic [1:0] aluOp;
      logic       illegal;
   } ctrl_t;

   typedef struct {
      int    st;
      ctrl_t c;
      logic  rdy;
   } step_t;

   logic       clk;
   logic       reset;
   logic [3:0] opcode;
   logic       mem_ready;
   logic       pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write;
   logic       reg_write, reg_dst, mem_to_reg, alu_src_a, illegal_op;
   logic [1:0] alu_src_b, pc_src, alu_op;
   logic [3:0] state;
   ctrl_t      obs;

   int checks   = 0;
   int failures = 0;
   int lastCycles;
   int lastMemWr;
   int lastIllegal;
   step_t q[$];

   main_control_fsm dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
      .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
      .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
      .alu_op(alu_op), .illegal_op(illegal_op), .state(state)
   );

   assign obs = ctrl_t'({pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write,
                         reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src,
                         alu_op, illegal_op});

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expand one instruction into its expected per-cycle state and controls
   task automatic buildSeq(input logic [3:0] op, input int wf, input int wm);
      ctrl_t c;
      q.delete();
      for (int i = 0; i <= wf; i++) begin
         c = '0; c.memRead = 1'b1; c.srcB = 2'b01; c.aluOp = 2'b10;
         c.irWrite = (i == wf); c.pcWrite = (i == wf);
         q.push_back('{0, c, logic'(i == wf)});
      end
      c = '0; c.srcB = 2'b11; c.aluOp = 2'b10; c.illegal = (op > 4'd6);
      q.push_back('{1, c, logic'($urandom_range(0, 1))});
      if (op == 4'd1 || op == 4'd2) begin
         c = '0; c.srcA = 1'b1; c.srcB = 2'b10; c.aluOp = 2'b10;
         q.push_back('{2, c, logic'($urandom_range(0, 1))});
         for (int i = 0; i <= wm; i++) begin
            c = '0; c.iord = 1'b1;
            if (op == 4'd1) c.memRead = 1'b1; else c.memWrite = 1'b1;
            q.push_back('{(op == 4'd1) ? 3 : 5, c, logic'(i == wm)});
         end
         if (op == 4'd1) begin
            c = '0; c.regWrite = 1'b1; c.memToReg = 1'b1;
            q.push_back('{4, c, logic'($urandom_range(0, 1))});
         end
      end else if (op == 4'd0) begin
         c = '0; c.srcA = 1'b1;
         q.push_back('{6, c, logic'($urandom_range(0, 1))});
         c = '0; c.regWrite = 1'b1; c.regDst = 1'b1;
         q.push_back('{7, c, logic'($urandom_range(0, 1))});
      end else if (op == 4'd3) begin
         c = '0; c.srcA = 1'b1; c.aluOp = 2'b01; c.pcWriteCond = 1'b1; c.pcSrc = 2'b01;
         q.push_back('{8, c, logic'($urandom_range(0, 1))});
      end else if (op == 4'd6) begin
         c = '0; c.pcWrite = 1'b1; c.pcSrc = 2'b10;
         q.push_back('{9, c, logic'($urandom_range(0, 1))});
      end else if (op == 4'd4 || op == 4'd5) begin
         c = '0; c.srcA = 1'b1; c.srcB = 2'b10; c.aluOp = (op == 4'd5) ? 2'b11 : 2'b10;
         q.push_back('{10, c, logic'($urandom_range(0, 1))});
         c = '0; c.regWrite = 1'b1;
         q.push_back('{11, c, logic'($urandom_range(0, 1))});
      end
   endtask

   // Run one instruction cycle by cycle, comparing against the expansion
   task automatic runInstr(input string name, input logic [3:0] op, input int wf, input int wm);
      buildSeq(op, wf, wm);
      lastCycles = 0; lastMemWr = 0; lastIllegal = 0;
      foreach (q[i]) begin
         @(negedge clk);
         opcode    = (q[i].st == 0) ? 4'($urandom) : op;
         mem_ready = q[i].rdy;
         #1;
         checks++;
         if (state !== 4'(q[i].st) || obs !== q[i].c) begin
            failures++;
            $display("[TB] FAIL %s op=%0d cyc=%0d state act=%0d exp=%0d ctrl act=%h exp=%h",
                     name, op, i, state, q[i].st, obs, q[i].c);
         end
         lastCycles++;
         if (mem_write)  lastMemWr++;
         if (illegal_op) lastIllegal++;
      end
   endtask

   task automatic test_reset();
      ctrl_t fw;
      reset = 1'b1; mem_ready = 1'b0; opcode = 4'd1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      // walk LW into MEM_READ and stall there
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         mem_ready = (i == 0);
      end
      mem_ready = 1'b0;
      #1;
      checks++;
      if (state !== 4'd3) begin
         failures++;
         $display("[TB] FAIL reset_setup state act=%0d exp=3", state);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         reset = 1'b1; mem_ready = logic'($urandom_range(0, 1));
         #1;
         checks++;
         if (obs !== '0 || state !== 4'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs cyc=%0d ctrl act=%h exp=0 state act=%0d exp=0", i, obs, state);
         end
      end
      @(negedge clk);
      reset = 1'b0; mem_ready = 1'b0;
      #1;
      fw = '0; fw.memRead = 1'b1; fw.srcB = 2'b01; fw.aluOp = 2'b10;
      checks++;
      if (state !== 4'd0 || obs !== fw) begin
         failures++;
         $display("[TB] FAIL reset_release state act=%0d exp=0 ctrl act=%h exp=%h", state, obs, fw);
      end
   endtask

   task automatic test_lw();
      runInstr("lw", 4'd1, 0, 0);
      checks++;
      if (lastCycles !== 5) begin
         failures++;
         $display("[TB] FAIL lw_latency act=%0d exp=5", lastCycles);
      end
   endtask

   task automatic test_sw_wait();
      runInstr("sw", 4'd2, 0, 2);
      checks++;
      if (lastCycles !== 6 || lastMemWr !== 3) begin
         failures++;
         $display("[TB] FAIL sw_wait cycles act=%0d exp=6 memwr act=%0d exp=3", lastCycles, lastMemWr);
      end
   endtask

   task automatic test_rtype();
      runInstr("rtype", 4'd0, 1, 0);
      checks++;
      if (lastCycles !== 5) begin
         failures++;
         $display("[TB] FAIL rtype_latency act=%0d exp=5", lastCycles);
      end
   endtask

   task automatic test_branch_jump_slti();
      runInstr("beq", 4'd3, 0, 0);
      checks++;
      if (lastCycles !== 3) begin
         failures++;
         $display("[TB] FAIL beq_latency act=%0d exp=3", lastCycles);
      end
      runInstr("jump", 4'd6, 0, 0);
      runInstr("slti", 4'd5, 0, 0);
      runInstr("addi", 4'd4, 2, 0);
      checks++;
      if (lastCycles !== 6) begin
         failures++;
         $display("[TB] FAIL addi_latency act=%0d exp=6", lastCycles);
      end
   endtask

   task automatic test_illegal();
      runInstr("illegal", 4'b1010, 0, 0);
      checks++;
      if (lastCycles !== 2 || lastIllegal !== 1) begin
         failures++;
         $display("[TB] FAIL illegal cycles act=%0d exp=2 pulses act=%0d exp=1", lastCycles, lastIllegal);
      end
      runInstr("illegal_max", 4'b1111, 0, 0);
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 40; n++)
         runInstr("random", 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      checks++;
      if (state !== 4'd0) begin
         failures++;
         $display("[TB] FAIL final_fetch state act=%0d exp=0", state);
      end
   endtask

   // Test sequence
   initial begin
      test_reset();
      test_lw();
      test_sw_wait();
      test_rtype();
      test_branch_jump_slti();
      test_illegal();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
